regfile_dump: RTL and testbench

Debug read-out engine for the MIPS register file. On a start pulse it walks register addresses 0..NUM_REGS-1 through a read-only register-file port and serializes each 32-bit word into an 8-bit byte stream with a valid/ready handshake. The byte stream feeds the debug UART transmitter. It is the external reader of the register file; the pipeline's writeback stage remains the only writer.

---
 rtl/regfile_dump.sv | 181 ++++++++++++++++++
 tb/tb_regfile_dump.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks register addresses 0..NUM_REGS-1 and streams each
// 32-bit word as four bytes, MSB first. Define REGDUMP_CHECKSUM_EN for a trailing XOR byte.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StartIn,
    output logic [ADDR_W-1:0] RAddrOut,
    input  logic [31:0]       RDataIn,
    output logic [7:0]        ByteOut,
    output logic              ByteValidOut,
    input  logic              ByteReadyIn,
    output logic              BusyOut,
    output logic              DoneOut
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM = 3'd4,
`endif
        S_DONE = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [31:0]       r_shift;
    logic [1:0]        r_idx;
    logic [7:0]        r_byte;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [31:0]       w_shift_nxt;
    logic [1:0]        w_idx_nxt;
    logic [7:0]        w_byte_nxt;
    logic              w_valid_nxt;
    logic              w_xfer;

`ifdef REGDUMP_CHECKSUM_EN
    logic [7:0]        r_csum;
    logic [7:0]        w_csum_nxt;
`endif

    // r_valid mirrors SEND/CSUM, so a transfer never depends on ready combinationally.
    assign w_xfer = r_valid & ByteReadyIn;

    // Next-state and datapath logic; outputs are computed from the next state so they register cleanly.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
`ifdef REGDUMP_CHECKSUM_EN
        w_csum_nxt  = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                if (StartIn) begin
                    w_state_nxt = S_ADDR;
                    w_cnt_nxt   = {ADDR_W{1'b0}};
`ifdef REGDUMP_CHECKSUM_EN
                    w_csum_nxt  = 8'h00;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADDR: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_shift_nxt = RDataIn;
                w_idx_nxt   = 2'd0;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_xfer) begin
                    w_shift_nxt = {r_shift[23:0], 8'h00};
                    w_idx_nxt   = r_idx + 2'd1;
`ifdef REGDUMP_CHECKSUM_EN
                    w_csum_nxt  = r_csum ^ r_shift[31:24];
`endif
                    if (r_idx == 2'd3) begin
                        if (r_cnt == LAST_ADDR) begin
`ifdef REGDUMP_CHECKSUM_EN
                            w_state_nxt = S_CSUM;
`else
                            w_state_nxt = S_DONE;
`endif
                        end else begin
                            w_cnt_nxt   = r_cnt + ADDR_W'(1);
                            w_state_nxt = S_ADDR;
                        end
                    end else begin
                        w_state_nxt = S_SEND;
                    end
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                if (w_xfer) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CSUM;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_SEND: begin
                w_valid_nxt = 1'b1;
                w_byte_nxt  = w_shift_nxt[31:24];
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                w_valid_nxt = 1'b1;
                w_byte_nxt  = w_csum_nxt;
            end
`endif
            default: begin
                w_valid_nxt = 1'b0;
                w_byte_nxt  = 8'h00;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= {ADDR_W{1'b0}};
            r_shift <= 32'h0000_0000;
            r_idx   <= 2'd0;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            r_csum  <= 8'h00;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_byte  <= w_byte_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
`ifdef REGDUMP_CHECKSUM_EN
            r_csum  <= w_csum_nxt;
`endif
        end
    end

    assign RAddrOut     = r_cnt;
    assign ByteOut      = r_byte;
    assign ByteValidOut = r_valid;
    assign BusyOut      = r_busy;
    assign DoneOut      = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: reset, full dump, back-pressure, restart, mid-dump reset, random ready.
module tb_regfile_dump;
    localparam int N  = 32;
    localparam int AW = 5;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int NBYTES    = N * 4 + 1;
    localparam int DONE_BASE = 1 + 6 * N + 1;
`else
    localparam int NBYTES    = N * 4;
    localparam int DONE_BASE = 1 + 6 * N;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          StartIn;
    logic [AW-1:0] RAddrOut;
    logic [31:0]   RDataIn;
    logic [7:0]    ByteOut;
    logic          ByteValidOut;
    logic          ByteReadyIn;
    logic          BusyOut;
    logic          DoneOut;

    logic [31:0]   regs [N];
    assign RDataIn = regs[RAddrOut];

    regfile_dump #(.NUM_REGS(N), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .StartIn(StartIn), .RAddrOut(RAddrOut), .RDataIn(RDataIn),
        .ByteOut(ByteOut), .ByteValidOut(ByteValidOut), .ByteReadyIn(ByteReadyIn),
        .BusyOut(BusyOut), .DoneOut(DoneOut)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         t0    = 0;
    logic [7:0] q [$];
    int         done_cnt = 0;
    int         done_rel = -1;
    int         stalls   = 0;
    bit         mon_en   = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte;
    logic [AW-1:0] prev_addr;

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: inputs change just after posedge, so negedge values are what the next edge samples.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                total++;
                if (ByteValidOut !== 1'b1 || ByteOut !== prev_byte || RAddrOut !== prev_addr) begin
                    bad++;
                    $display("FAIL stall_stable: valid=%b byte=%h addr=%0d, required valid=1 byte=%h addr=%0d",
                             ByteValidOut, ByteOut, RAddrOut, prev_byte, prev_addr);
                end
            end
            if (ByteValidOut === 1'b1) begin
                total++;
                if (BusyOut !== 1'b1 || DoneOut !== 1'b0) begin
                    bad++;
                    $display("FAIL valid_outside_send: busy=%b done=%b, required busy=1 done=0", BusyOut, DoneOut);
                end
            end
            if (ByteValidOut === 1'b1 && ByteReadyIn === 1'b1) q.push_back(ByteOut);
            if (ByteValidOut === 1'b1 && ByteReadyIn === 1'b0) stalls++;
            if (DoneOut === 1'b1) begin
                done_cnt++;
                done_rel = cyc - t0 + 1;
            end
            prev_stall = (ByteValidOut === 1'b1) && (ByteReadyIn === 1'b0) && (reset === 1'b0);
            prev_byte  = ByteOut;
            prev_addr  = RAddrOut;
        end
    end

    function automatic logic [7:0] exp_byte(input int k);
        logic [31:0] w;
        logic [7:0]  x;
        if (k < N * 4) begin
            w = regs[k / 4];
            return w[8 * (3 - k % 4) +: 8];
        end
        x = 8'h00;
        for (int i = 0; i < N * 4; i++) begin
            w = regs[i / 4];
            x = x ^ w[8 * (3 - i % 4) +: 8];
        end
        return x;
    endfunction

    function automatic int stream_errors();
        int e = 0;
        for (int i = 0; i < NBYTES; i++) begin
            if (i >= q.size()) e++;
            else if (q[i] !== exp_byte(i)) e++;
        end
        return e;
    endfunction

    task automatic start_dump();
        q.delete();
        done_cnt   = 0;
        done_rel   = -1;
        stalls     = 0;
        prev_stall = 1'b0;
        mon_en     = 1'b1;
        @(posedge clk); #1 StartIn = 1'b1;
        @(posedge clk); #1 StartIn = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int maxc, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(posedge clk); #1;
            if (rnd) ByteReadyIn = 1'($urandom_range(0, 1));
            if (done_cnt > 0) ok = 1'b1;
        end
        ByteReadyIn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; StartIn = 1'b1; ByteReadyIn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({RAddrOut, ByteOut, ByteValidOut, BusyOut, DoneOut} !== {5'd0, 8'h00, 3'b000}) begin
            bad++;
            $display("FAIL reset_outputs: addr=%0d byte=%h valid=%b busy=%b done=%b, required all 0",
                     RAddrOut, ByteOut, ByteValidOut, BusyOut, DoneOut);
        end
        @(posedge clk); #1 reset = 1'b0; StartIn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (ByteValidOut !== 1'b0 || BusyOut !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle: cycle %0d valid=%b busy=%b, required 0 0", i, ByteValidOut, BusyOut);
            end
        end
    endtask

    task automatic test_full_dump();
        bit ok;
        logic [7:0] b;
        logic [31:0] want;
        for (int i = 0; i < N; i++) regs[i] = 32'h0000_0000;
        regs[5] = 32'hDEAD_BEEF;
        start_dump();
        wait_done(1000, 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL full_timeout: no DoneOut, required one within 1000 cycles"); end
        total++;
        if (q.size() != NBYTES) begin bad++; $display("FAIL full_count: %0d bytes, required %0d", q.size(), NBYTES); end
        total++;
        if (stream_errors() != 0) begin bad++; $display("FAIL full_stream: %0d bad bytes, required 0", stream_errors()); end
        want = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            b = (q.size() > 20 + i) ? q[20 + i] : 8'hxx;
            total++;
            if (b !== want[31 - 8 * i -: 8]) begin
                bad++;
                $display("FAIL full_r5_byte%0d: got %h, required %h", i, b, want[31 - 8 * i -: 8]);
            end
        end
`ifdef REGDUMP_CHECKSUM_EN
        b = (q.size() > 128) ? q[128] : 8'hxx;
        total++;
        if (b !== 8'h22) begin bad++; $display("FAIL full_checksum: got %h, required 22", b); end
`endif
        total++;
        if (done_rel != DONE_BASE) begin bad++; $display("FAIL full_done_cycle: %0d, required %0d", done_rel, DONE_BASE); end
        total++;
        if (done_cnt != 1 || BusyOut !== 1'b0) begin
            bad++;
            $display("FAIL full_done_once: done_cnt=%0d busy=%b, required 1 0", done_cnt, BusyOut);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        ByteReadyIn = 1'b0;
        start_dump();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (ByteValidOut !== 1'b1 || ByteOut !== 8'h00 || RAddrOut !== 5'd0) begin
                bad++;
                $display("FAIL bp_hold: stall %0d valid=%b byte=%h addr=%0d, required 1 00 0",
                         i, ByteValidOut, ByteOut, RAddrOut);
            end
            if (i < 9) @(negedge clk);
        end
        @(posedge clk); #1 ByteReadyIn = 1'b1;
        wait_done(1000, 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout: no DoneOut, required one within 1000 cycles"); end
        total++;
        if (stream_errors() != 0 || q.size() != NBYTES) begin
            bad++;
            $display("FAIL bp_stream: %0d bytes with %0d errors, required %0d with 0", q.size(), stream_errors(), NBYTES);
        end
        total++;
        if (done_rel != DONE_BASE + 10 || stalls != 10) begin
            bad++;
            $display("FAIL bp_done_cycle: done=%0d stalls=%0d, required %0d 10", done_rel, stalls, DONE_BASE + 10);
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        start_dump();
        repeat (49) @(posedge clk);
        #1 StartIn = 1'b1;
        @(posedge clk); #1 StartIn = 1'b0;
        wait_done(1000, 1'b0, ok);
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (!ok) begin bad++; $display("FAIL busy_timeout: no DoneOut, required one within 1000 cycles"); end
        total++;
        if (q.size() != NBYTES || stream_errors() != 0) begin
            bad++;
            $display("FAIL busy_stream: %0d bytes with %0d errors, required %0d with 0", q.size(), stream_errors(), NBYTES);
        end
        total++;
        if (done_cnt != 1 || done_rel != DONE_BASE || BusyOut !== 1'b0) begin
            bad++;
            $display("FAIL busy_single_done: count=%0d cycle=%0d busy=%b, required 1 %0d 0",
                     done_cnt, done_rel, BusyOut, DONE_BASE);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_dump();
        repeat (99) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (ByteValidOut !== 1'b0 || BusyOut !== 1'b0 || DoneOut !== 1'b0 || RAddrOut !== 5'd0 || ByteOut !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset_outputs: valid=%b busy=%b done=%b addr=%0d byte=%h, required all 0",
                     ByteValidOut, BusyOut, DoneOut, RAddrOut, ByteOut);
        end
        repeat (10) @(negedge clk);
        total++;
        if (done_cnt != 0 || BusyOut !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_no_done: done_cnt=%0d busy=%b, required 0 0", done_cnt, BusyOut);
        end
        start_dump();
        wait_done(1000, 1'b0, ok);
        total++;
        if (!ok || q.size() != NBYTES || stream_errors() != 0 || done_rel != DONE_BASE) begin
            bad++;
            $display("FAIL mid_reset_redump: ok=%b bytes=%0d errors=%0d done=%0d, required 1 %0d 0 %0d",
                     ok, q.size(), stream_errors(), done_rel, NBYTES, DONE_BASE);
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        for (int i = 0; i < N; i++) regs[i] = i * 32'h0102_0304;
        ByteReadyIn = 1'($urandom_range(0, 1));
        start_dump();
        wait_done(3000, 1'b1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rand_timeout: no DoneOut, required one within 3000 cycles"); end
        total++;
        if (q.size() != NBYTES || stream_errors() != 0) begin
            bad++;
            $display("FAIL rand_stream: %0d bytes with %0d errors, required %0d with 0", q.size(), stream_errors(), NBYTES);
        end
        total++;
        if (done_rel != DONE_BASE + stalls || done_cnt != 1) begin
            bad++;
            $display("FAIL rand_done_cycle: cycle=%0d count=%0d, required %0d 1", done_rel, done_cnt, DONE_BASE + stalls);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) regs[i] = 32'h0000_0000;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_random_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end
endmodule
